// File: rtl/dff.sv
// Positive-edge D register with async active-high reset, optionally a WIDTH-bit, STAGES-deep
// delay line. Defining DFF_QN_EN adds the inverted output port Qn.
module dff #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef DFF_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "dff: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $fatal(1, "dff: STAGES must be >= 1");
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    // Reset overrides the clock, so an edge coinciding with reset release does not capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= D;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign Q = stage_q[STAGES-1];

`ifdef DFF_QN_EN
    assign Qn = ~stage_q[STAGES-1];
`endif

endmodule

// File: tb/tb_dff.sv
// Bench for dff: a 1-bit single-stage cell and an 8-bit 3-stage delay line (reset 8'hA5).
// Expected outputs are queued by the stimulus and checked by a separate monitor.
module tb_dff;

    logic       clk;
    logic       rst;
    logic       D1;
    logic       Q1;
    logic [7:0] D8;
    logic [7:0] Q8;
`ifdef DFF_QN_EN
    logic       Qn1;
    logic [7:0] Qn8;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    typedef struct {
        logic       d1;
        logic [7:0] d8;
        logic       e1;
        logic [7:0] e8;
        bit         glitch;
    } row_t;

    exp_t sb[$];
    row_t rows[$];

    dff #(
        .WIDTH      (1),
        .STAGES     (1),
        .RESET_VALUE(1'b0)
    ) u_dff1 (
        .clk(clk),
        .rst(rst),
        .D  (D1),
        .Q  (Q1)
`ifdef DFF_QN_EN
        ,
        .Qn (Qn1)
`endif
    );

    dff #(
        .WIDTH      (8),
        .STAGES     (3),
        .RESET_VALUE(8'hA5)
    ) u_dff8 (
        .clk(clk),
        .rst(rst),
        .D  (D8),
        .Q  (Q8)
`ifdef DFF_QN_EN
        ,
        .Qn (Qn8)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_now(input string name, input exp_t e);
        chk({name, "_q1"}, {7'd0, Q1}, {7'd0, e.q1});
        chk({name, "_q8"}, Q8, e.q8);
`ifdef DFF_QN_EN
        chk({name, "_qn1"}, {7'd0, Qn1}, {7'd0, ~e.q1});
        chk({name, "_qn8"}, Qn8, ~e.q8);
`endif
    endtask

    // Monitor: one queued expectation per rising edge, sampled 5 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #5;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_now("edge", e);
            end
        end
    end

    task automatic run_row(input row_t r, input logic prev1);
        if (r.glitch) begin
            D1 = ~r.d1;
            #2;
            chk("hold_q1", {7'd0, Q1}, {7'd0, prev1});
        end
        D1 = r.d1;
        D8 = r.d8;
        sb.push_back('{q1: r.e1, q8: r.e8});
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    initial begin
        logic prev1;

        // Release phase: STAGES=3 line shows 8'h01 on the third edge after it was sampled.
        rows.push_back('{1'b1, 8'h01, 1'b1, 8'hA5, 1'b0});
        rows.push_back('{1'b1, 8'h02, 1'b1, 8'hA5, 1'b0});
        rows.push_back('{1'b1, 8'h03, 1'b1, 8'h01, 1'b0});
        rows.push_back('{1'b1, 8'h04, 1'b1, 8'h02, 1'b0});
        rows.push_back('{1'b1, 8'h05, 1'b1, 8'h03, 1'b0});
        rows.push_back('{1'b0, 8'h06, 1'b0, 8'h04, 1'b0});
        rows.push_back('{1'b0, 8'h07, 1'b0, 8'h05, 1'b1});
        rows.push_back('{1'b1, 8'h08, 1'b1, 8'h06, 1'b0});
        rows.push_back('{1'b0, 8'h09, 1'b0, 8'h07, 1'b1});
        rows.push_back('{1'b1, 8'h0A, 1'b1, 8'h08, 1'b0});
        // Refill after mid-operation reset.
        rows.push_back('{1'b1, 8'h0C, 1'b1, 8'hA5, 1'b0});
        rows.push_back('{1'b1, 8'h0D, 1'b1, 8'hA5, 1'b0});
        rows.push_back('{1'b0, 8'h0E, 1'b0, 8'h0C, 1'b0});
        rows.push_back('{1'b0, 8'h0F, 1'b0, 8'h0D, 1'b0});

        rst = 1'b0;
        D1  = 1'b0;
        D8  = 8'h00;
        #1;
        rst = 1'b1;
        #1;
        chk_now("por", '{q1: 1'b0, q8: 8'hA5});
        // Reset held across edges 10..90.
        for (int i = 0; i < 5; i++) sb.push_back('{q1: 1'b0, q8: 8'hA5});

        #98;
        rst   = 1'b0;
        prev1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_row(rows[i], prev1);
            prev1 = rows[i].e1;
        end

        // Async reset in the low phase of clk, checked before the next edge.
        #2;
        rst = 1'b1;
        #1;
        chk_now("async_rst", '{q1: 1'b0, q8: 8'hA5});
        D1 = 1'b1;
        D8 = 8'h0B;
        sb.push_back('{q1: 1'b0, q8: 8'hA5});
        sb.push_back('{q1: 1'b0, q8: 8'hA5});
        @(posedge clk);
        @(posedge clk);
        // Release coincides with this edge; it must not capture.
        rst <= 1'b0;
        @(negedge clk);
        #2;
        prev1 = 1'b0;
        for (int i = 10; i < 14; i++) begin
            run_row(rows[i], prev1);
            prev1 = rows[i].e1;
        end

        #40;
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
